// File: rtl/change_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : change_calc_pkg
//  Description : Shared constants for the change calculator: default datapath
//                width and the FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package change_calc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/change_calc_if.sv
`default_nettype none
// ============================================================================
//  Module      : change_calc_if
//  Description : Request/result bundle of the change calculator.
//                master : price_load, price, coin_valid, coin_val, confirm,
//                         cancel out; busy, change_valid, change, short,
//                         refund, ovf, led in.
//                slave  : the mirror image (used by change_calc).
//  Revision    : 1.0 - initial release
// ============================================================================
interface change_calc_if
  import change_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             price_load;
  logic [WIDTH-1:0] price;
  logic             coin_valid;
  logic [WIDTH-1:0] coin_val;
  logic             confirm;
  logic             cancel;
  logic             busy;
  logic             change_valid;
  logic [WIDTH-1:0] change;
  logic             short;
  logic             refund;
  logic             ovf;
  logic [WIDTH:0]   led;

  modport master (
    output price_load, price, coin_valid, coin_val, confirm, cancel,
    input  busy, change_valid, change, short, refund, ovf, led
  );

  modport slave (
    input  price_load, price, coin_valid, coin_val, confirm, cancel,
    output busy, change_valid, change, short, refund, ovf, led
  );

endinterface
`default_nettype wire

// File: rtl/change_calc_full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : One-bit full adder, one stage of the subtract ripple chain.
//                Ports: a, b, cin in; sum, cout out.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  output logic      sum,
  output logic      cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign sum    = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule
`default_nettype wire

// File: rtl/change_calc.sv
`default_nettype none
// ============================================================================
//  Module      : change_calc
//  Description : Ticket-machine change calculator. Accumulates coins
//                (saturating), then on confirm computes paid - price through
//                a ripple chain of full_adder_bit stages, or on cancel
//                refunds everything paid.
//                Ports: clk, rst (async, active-high); bus (change_calc_if
//                slave) carrying the price/coin/confirm/cancel requests and
//                the busy/change_valid/change/short/refund/ovf/led results.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_calc
  import change_calc_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  change_calc_if.slave bus
);

  localparam logic [WIDTH:0] C_LED_RESET =
    (LED_ACTIVE_LOW != 0) ? {(WIDTH+1){1'b1}} : {(WIDTH+1){1'b0}};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_paid;
  logic [WIDTH-1:0] r_price;
  logic [WIDTH-1:0] r_change;
  logic             r_short;
  logic             r_refund;
  logic             r_ovf;
  logic             r_change_valid;
  logic             r_refund_mode;
  logic [WIDTH:0]   r_led;

  logic             w_accept;
  logic             w_coin_take;
  logic [WIDTH:0]   w_coin_sum;
  logic [WIDTH-1:0] w_paid_in;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res_change;
  logic             w_res_short;
  logic             w_res_refund;
  logic [WIDTH-1:0] w_res_paid;
  logic [WIDTH:0]   w_res_led;

  // Requests are only honoured while idle or accumulating.
  assign w_accept    = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_coin_take = w_accept && bus.coin_valid;
  assign w_coin_sum  = {1'b0, r_paid} + {1'b0, bus.coin_val};
  assign w_paid_in   = !w_coin_take   ? r_paid :
                       w_coin_sum[WIDTH] ? {WIDTH{1'b1}} : w_coin_sum[WIDTH-1:0];

  // paid + ~price + 1: carry-in of 1 completes the two's complement.
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    full_adder_bit u_fa (
      .a    (r_paid[i]),
      .b    (~r_price[i]),
      .cin  (w_carry[i]),
      .sum  (w_diff[i]),
      .cout (w_carry[i+1])
    );
  end

  // Outcome of the CALC cycle; a clear final carry means paid < price.
  always_comb begin
    w_res_change = '0;
    w_res_short  = 1'b0;
    w_res_refund = 1'b0;
    w_res_paid   = r_paid;
    if (r_refund_mode) begin
      w_res_change = r_paid;
      w_res_refund = 1'b1;
      w_res_paid   = '0;
    end else if (w_carry[WIDTH]) begin
      w_res_change = w_diff;
      w_res_paid   = '0;
    end else begin
      w_res_short  = 1'b1;
    end
  end

  assign w_res_led = (LED_ACTIVE_LOW != 0) ? ~{w_res_short, w_res_change}
                                           :  {w_res_short, w_res_change};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_paid         <= '0;
      r_price        <= '0;
      r_change       <= '0;
      r_short        <= 1'b0;
      r_refund       <= 1'b0;
      r_ovf          <= 1'b0;
      r_change_valid <= 1'b0;
      r_refund_mode  <= 1'b0;
      r_led          <= C_LED_RESET;
    end else begin
      // Results are registered on CALC->DONE; the pulse follows DONE so it
      // lands on the edge after the results settle.
      r_change_valid <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (r_state == ST_IDLE && bus.price_load) begin
            r_price <= bus.price;
          end
          r_paid <= w_paid_in;
          if (w_coin_take && w_coin_sum[WIDTH]) begin
            r_ovf <= 1'b1;
          end
          if (bus.cancel || bus.confirm) begin
            r_refund_mode <= bus.cancel;
            r_state       <= ST_CALC;
          end else if (bus.coin_valid) begin
            r_state <= ST_ACCUM;
          end
        end
        ST_CALC: begin
          r_change <= w_res_change;
          r_short  <= w_res_short;
          r_refund <= w_res_refund;
          r_paid   <= w_res_paid;
          r_led    <= w_res_led;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          // A short sale keeps its coins and stays in ACCUM unless nothing
          // was paid at all.
          if (r_paid == '0) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign bus.change_valid = r_change_valid;
  assign bus.change       = r_change;
  assign bus.short        = r_short;
  assign bus.refund       = r_refund;
  assign bus.ovf          = r_ovf;
  assign bus.led          = r_led;

endmodule
`default_nettype wire

// File: tb/tb_change_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_calc
//  Description : Self-checking bench for change_calc (WIDTH=8, active-low
//                LEDs): a table of sale/refund vectors plus hand-written
//                sequences for latency, ignored inputs and reset aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_change_calc;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  change_calc_if #(.WIDTH(W)) bus ();

  change_calc #(.WIDTH(W), .LED_ACTIVE_LOW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] price;
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    int           ncoins;
    logic         do_cancel;
    logic         exp_ovf;
    logic [W-1:0] exp_change;
    logic         exp_short;
    logic         exp_refund;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.price_load = 1'b0;
    bus.price      = '0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.confirm    = 1'b0;
    bus.cancel     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_price(input logic [W-1:0] p);
    bus.price = p;
    bus.price_load = 1'b1;
    tick();
    bus.price_load = 1'b0;
  endtask

  task automatic coin(input logic [W-1:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_val = v;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  // Returns the number of edges from the request edge until change_valid.
  task automatic wait_valid(output int edges);
    edges = 0;
    for (int i = 1; i <= 10 && edges == 0; i++) begin
      tick();
      if (bus.change_valid) edges = i + 1;
    end
  endtask

  function automatic logic [W:0] led_of(input logic s, input logic [W-1:0] c);
    return ~{s, c};
  endfunction

  initial begin
    int edges;
    int seen;

    vecs[0] = '{8'd30,  8'd20,  8'd20,  2, 1'b0, 1'b0, 8'd10,  1'b0, 1'b0};
    vecs[1] = '{8'd50,  8'd20,  8'd0,   1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd100, 8'd200, 2, 1'b1, 1'b1, 8'd255, 1'b0, 1'b1};
    vecs[3] = '{8'd40,  8'd40,  8'd0,   1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0};
    vecs[4] = '{8'd200, 8'd100, 8'd0,   1, 1'b1, 1'b0, 8'd100, 1'b0, 1'b1};
    vecs[5] = '{8'd1,   8'd255, 8'd0,   1, 1'b0, 1'b0, 8'd254, 1'b0, 1'b0};
    vecs[6] = '{8'd255, 8'd254, 8'd0,   1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[7] = '{8'd7,   8'd0,   8'd0,   0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[8] = '{8'd0,   8'd0,   8'd0,   0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0};
    vecs[9] = '{8'd100, 8'd60,  8'd50,  2, 1'b0, 1'b0, 8'd10,  1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_busy",   bus.busy, 0);
    check("rst_valid",  bus.change_valid, 0);
    check("rst_change", bus.change, 0);
    check("rst_short",  bus.short, 0);
    check("rst_refund", bus.refund, 0);
    check("rst_ovf",    bus.ovf, 0);
    check("rst_led",    bus.led, 9'h1FF);

    // Table-driven sales and refunds
    for (int v = 0; v < 10; v++) begin
      do_reset();
      load_price(vecs[v].price);
      for (int c = 0; c < vecs[v].ncoins; c++) coin(c == 0 ? vecs[v].c0 : vecs[v].c1);
      check($sformatf("v%0d_ovf", v), bus.ovf, vecs[v].exp_ovf);
      if (vecs[v].do_cancel) bus.cancel = 1'b1; else bus.confirm = 1'b1;
      tick();
      bus.cancel = 1'b0;
      bus.confirm = 1'b0;
      wait_valid(edges);
      check($sformatf("v%0d_latency", v), edges, 3);
      check($sformatf("v%0d_change", v), bus.change, vecs[v].exp_change);
      check($sformatf("v%0d_short", v),  bus.short, vecs[v].exp_short);
      check($sformatf("v%0d_refund", v), bus.refund, vecs[v].exp_refund);
      check($sformatf("v%0d_led", v),    bus.led, led_of(vecs[v].exp_short, vecs[v].exp_change));
    end

    // Short sale keeps coins; topping up then completes the sale
    do_reset();
    load_price(8'd50);
    coin(8'd20);
    bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    wait_valid(edges);
    check("short1_short", bus.short, 1);
    check("short1_led", bus.led, 9'h0FF);
    coin(8'd40);
    bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    wait_valid(edges);
    check("short2_found", edges, 3);
    check("short2_change", bus.change, 10);
    check("short2_short", bus.short, 0);

    // Saturation sticks until the refund returns to IDLE
    do_reset();
    coin(8'd100);
    coin(8'd200);
    coin(8'd1);
    check("ovf_sticky", bus.ovf, 1);
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    wait_valid(edges);
    check("ovf_refund_change", bus.change, 255);
    check("ovf_cleared", bus.ovf, 0);

    // Coin, confirm and cancel together: cancel wins, coin counted
    do_reset();
    load_price(8'd10);
    bus.coin_valid = 1'b1; bus.coin_val = 8'd25; bus.confirm = 1'b1; bus.cancel = 1'b1;
    tick();
    clear_inputs();
    wait_valid(edges);
    check("both_refund", bus.refund, 1);
    check("both_change", bus.change, 25);
    check("both_short", bus.short, 0);

    // Exact latency with coin+confirm; inputs in CALC/DONE ignored
    do_reset();
    load_price(8'd40);
    bus.coin_valid = 1'b1; bus.coin_val = 8'd40; bus.confirm = 1'b1;
    tick();
    bus.coin_val = 8'd5; bus.price_load = 1'b1; bus.price = 8'd0;
    check("lat_k_busy", bus.busy, 1);
    check("lat_k_valid", bus.change_valid, 0);
    tick();
    check("lat_k1_busy", bus.busy, 1);
    check("lat_k1_valid", bus.change_valid, 0);
    tick();
    clear_inputs();
    check("lat_k2_valid", bus.change_valid, 1);
    check("lat_k2_busy", bus.busy, 0);
    check("lat_k2_change", bus.change, 0);
    check("lat_k2_short", bus.short, 0);
    tick();
    check("lat_k3_valid", bus.change_valid, 0);
    bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    wait_valid(edges);
    check("ignored_short", bus.short, 1);

    // price_load outside IDLE ignored
    do_reset();
    load_price(8'd50);
    coin(8'd60);
    load_price(8'd10);
    bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    wait_valid(edges);
    check("pl_accum_change", bus.change, 10);

    // Reset in CALC aborts without a result
    do_reset();
    load_price(8'd10);
    coin(8'd10);
    bus.confirm = 1'b1; tick(); bus.confirm = 1'b0;
    check("abort_busy_calc", bus.busy, 1);
    #2 rst = 1'b1;
    #1 check("abort_busy_async", bus.busy, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      if (bus.change_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_change", bus.change, 0);
    check("abort_short", bus.short, 0);
    check("abort_refund", bus.refund, 0);
    check("abort_led", bus.led, 9'h1FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
